// File: rtl/serial_xfer_clk.sv
// Serial-port shift clock and transfer sequencer: internal clock at normal/fast rate or a
// synchronised external clock, with per-bit shift strobes and an end-of-transfer pulse.
module serial_xfer_clk #(
    parameter int unsigned HALF_NORMAL = 256,
    parameter int unsigned HALF_FAST   = 8,
    parameter int unsigned BITS        = 8,
    parameter int unsigned DIV_W       =
        $clog2((HALF_NORMAL > HALF_FAST) ? HALF_NORMAL : HALF_FAST),
    parameter int unsigned BC_W        = $clog2(BITS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            internal,
    input  logic            fast,
    input  logic            ext_sclk,
    output logic            sclk_out,
    output logic            shift_out_en,
    output logic            shift_in_en,
    output logic            busy,
    output logic            done,
    output logic [BC_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {StIdle, StILow, StIHigh, StExt} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   half_m1;
    logic               fast_lat;
    logic               sync1;
    logic               sync2;
    logic               hist;
    logic               div_term;
    logic               ext_fall;
    logic               ext_rise;

    assign half_m1  = fast_lat ? DIV_W'(HALF_FAST - 1) : DIV_W'(HALF_NORMAL - 1);
    assign div_term = (div_cnt == half_m1);
    assign ext_fall = hist & ~sync2;
    assign ext_rise = sync2 & ~hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            div_cnt      <= '0;
            fast_lat     <= 1'b0;
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            hist         <= 1'b1;
            sclk_out     <= 1'b1;
            shift_out_en <= 1'b0;
            shift_in_en  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bit_cnt      <= '0;
        end else begin
            // Synchroniser runs in every state so EXT starts from a settled history.
            sync1        <= ext_sclk;
            sync2        <= sync1;
            hist         <= sync2;
            shift_out_en <= 1'b0;
            shift_in_en  <= 1'b0;
            done         <= 1'b0;

            if (abort && state != StIdle) begin
                state    <= StIdle;
                sclk_out <= 1'b1;
                busy     <= 1'b0;
                bit_cnt  <= '0;
                div_cnt  <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start && !abort) begin
                            fast_lat <= fast;
                            busy     <= 1'b1;
                            bit_cnt  <= '0;
                            div_cnt  <= '0;
                            if (internal) begin
                                state        <= StILow;
                                sclk_out     <= 1'b0;
                                shift_out_en <= 1'b1;
                            end else begin
                                state <= StExt;
                            end
                        end
                    end
                    StILow: begin
                        if (div_term) begin
                            div_cnt     <= '0;
                            sclk_out    <= 1'b1;
                            shift_in_en <= 1'b1;
                            bit_cnt     <= bit_cnt + 1'b1;
                            state       <= StIHigh;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    StIHigh: begin
                        if (div_term) begin
                            div_cnt <= '0;
                            if (bit_cnt == BC_W'(BITS)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= StIdle;
                            end else begin
                                sclk_out     <= 1'b0;
                                shift_out_en <= 1'b1;
                                state        <= StILow;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    StExt: begin
                        if (ext_fall) begin
                            shift_out_en <= 1'b1;
                        end else if (ext_rise) begin
                            shift_in_en <= 1'b1;
                            bit_cnt     <= bit_cnt + 1'b1;
                            if (bit_cnt == BC_W'(BITS - 1)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= StIdle;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_xfer_clk.sv
// Bench for serial_xfer_clk: directed scenarios with randomized noise, checked every cycle
// against a timeline model computed from half-period arithmetic and ext edge times.
module tb_serial_xfer_clk;

    localparam int HN  = 256;
    localparam int HF  = 8;
    localparam int NB  = 8;
    localparam int BCW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic           internal;
    logic           fast;
    logic           ext_sclk;
    logic           sclk_out;
    logic           shift_out_en;
    logic           shift_in_en;
    logic           busy;
    logic           done;
    logic [BCW-1:0] bit_cnt;
    logic [8:0]     obs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_xfer_clk #(
        .HALF_NORMAL(HN),
        .HALF_FAST  (HF),
        .BITS       (NB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .internal    (internal),
        .fast        (fast),
        .ext_sclk    (ext_sclk),
        .sclk_out    (sclk_out),
        .shift_out_en(shift_out_en),
        .shift_in_en (shift_in_en),
        .busy        (busy),
        .done        (done),
        .bit_cnt     (bit_cnt)
    );

    // {sclk_out, shift_out_en, shift_in_en, busy, done, bit_cnt}
    assign obs = {sclk_out, shift_out_en, shift_in_en, busy, done, bit_cnt};

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    function automatic logic [8:0] idle_v(input int bc);
        return {1'b1, 4'b0000, BCW'(bc)};
    endfunction

    // t = edges since the start edge; sclk is low for the first half of each 2h bit slot.
    function automatic logic [8:0] exp_int(input int t, input int h);
        int  p;
        int  bc;
        logic sc, so, si, bz, dn;
        p = 2 * h * NB;
        if (t < p) begin
            sc = (t % (2 * h)) >= h;
            so = (t % (2 * h)) == 0;
            si = (t % (2 * h)) == h;
            bz = 1'b1;
            dn = 1'b0;
            bc = (t + h) / (2 * h);
        end else begin
            sc = 1'b1;
            so = 1'b0;
            si = 1'b0;
            bz = 1'b0;
            dn = (t == p);
            bc = NB;
        end
        return {sc, so, si, bz, dn, BCW'(bc)};
    endfunction

    // Each ext toggle after sample tt[i] yields a strobe 3 edges later; even i are falls.
    function automatic logic [8:0] exp_ext(input int t, input int tt[16]);
        logic so, si;
        int   bc;
        int   endt;
        so = 1'b0;
        si = 1'b0;
        bc = 0;
        endt = tt[15] + 3;
        for (int i = 0; i < 16; i++) begin
            if (tt[i] + 3 == t) begin
                if (i % 2 == 0) so = 1'b1;
                else            si = 1'b1;
            end
            if (i % 2 == 1 && tt[i] + 3 <= t) bc++;
        end
        return {1'b1, so, si, (t < endt), (t == endt), BCW'(bc)};
    endfunction

    task automatic run_int(input string tag, input bit fst, input bit pre, input int stop_at,
                           input bit use_reset, input bit noise, input int chain_fast);
        int h;
        int p;
        int last;
        h = fst ? HF : HN;
        p = 2 * h * NB;
        if (!pre) begin
            start    = 1'b1;
            internal = 1'b1;
            fast     = fst;
            abort    = 1'b0;
        end
        last = (stop_at >= 0) ? stop_at : ((chain_fast >= 0) ? p : p + 2);
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            chk(tag, obs, exp_int(t, h));
            start = 1'b0;
            if (noise) begin
                fast     = 1'($urandom_range(0, 1));
                internal = 1'($urandom_range(0, 1));
                if (t < p) start = 1'($urandom_range(0, 1));
            end
        end
        if (stop_at >= 0) begin
            if (use_reset) reset = 1'b1;
            else           abort = 1'b1;
            @(negedge clk);
            chk({tag, "_stop"}, obs, idle_v(0));
            reset = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            repeat (2 * h + 2) begin
                @(negedge clk);
                chk({tag, "_quiet"}, obs, idle_v(0));
            end
        end else if (chain_fast >= 0) begin
            start    = 1'b1;
            internal = 1'b1;
            fast     = chain_fast[0];
        end
    endtask

    task automatic idle_toggle(input string tag, input int bc);
        internal = 1'b0;
        repeat (12) begin
            ext_sclk = ~ext_sclk;
            repeat ($urandom_range(3, 6)) begin
                @(negedge clk);
                chk(tag, obs, idle_v(bc));
            end
        end
        repeat (4) begin
            @(negedge clk);
            chk(tag, obs, idle_v(bc));
        end
    endtask

    task automatic run_ext(input string tag, input bit noise);
        int tt[16];
        int cur;
        int endt;
        start    = 1'b1;
        internal = 1'b0;
        fast     = 1'($urandom_range(0, 1));
        abort    = 1'b0;
        cur = $urandom_range(1, 6);
        for (int i = 0; i < 16; i++) begin
            tt[i] = cur;
            cur += $urandom_range(4, 30);
        end
        endt = tt[15] + 3;
        for (int t = 0; t <= endt + 3; t++) begin
            @(negedge clk);
            chk(tag, obs, exp_ext(t, tt));
            start = 1'b0;
            if (noise) begin
                fast     = 1'($urandom_range(0, 1));
                internal = 1'($urandom_range(0, 1));
                if (t < endt) start = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 16; i++) begin
                if (tt[i] == t) ext_sclk = ~ext_sclk;
            end
        end
        internal = 1'b1;
    endtask

    initial begin
        int stop;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        internal = 1'b1;
        fast     = 1'b0;
        ext_sclk = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", obs, idle_v(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", obs, idle_v(0));

        run_int("t1_normal", 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);
        run_int("t2_fast_noise", 1'b1, 1'b0, -1, 1'b0, 1'b1, -1);

        abort = 1'b1;
        @(negedge clk);
        chk("abort_in_idle", obs, idle_v(NB));
        start = 1'b1;
        @(negedge clk);
        chk("start_abort_idle", obs, idle_v(NB));
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_after", obs, idle_v(NB));

        run_int("t3_abort", 1'b0, 1'b0, 5 * HN + 2, 1'b0, 1'b0, -1);
        run_int("t3_after_abort", 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);

        run_int("t4_busy_start", 1'b1, 1'b0, -1, 1'b0, 1'b1, 0);
        run_int("t4_chained", 1'b0, 1'b1, -1, 1'b0, 1'b1, 1);
        run_int("t4_chained2", 1'b1, 1'b1, -1, 1'b0, 1'b0, -1);

        idle_toggle("t5_idle_ext", NB);
        run_ext("t5_ext", 1'b0);
        idle_toggle("t5_idle_ext2", NB);
        run_ext("t5_ext_noise", 1'b1);
        run_ext("t5_ext_again", 1'b1);

        repeat (4) begin
            stop = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 2 * HF * NB - 1)) : -1;
            run_int("rand_fast", 1'b1, 1'b0, stop, 1'($urandom_range(0, 1)), 1'b1, -1);
        end

        run_int("t6_reset_mid", 1'b0, 1'b0, 9 * HN + 10, 1'b1, 1'b0, -1);
        run_int("t6_after_reset", 1'b0, 1'b0, -1, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
